pe_array_load_ctrl: RTL and testbench

Sequencer for the M×N PE array. It accepts one job per `start` pulse. For each job it streams ARRAY_M·ARRAY_N weight words from a valid/ready source into the PEs, one PE at a time, addressed by a walking one-hot select. It then holds the array in compute for a programmed number of cycles, waits out the systolic drain skew, and pulses `done`. It sits between the layer controller and the PE array, replacing free-running one-hot shifting with handshaked, counted sequencing.

---
 rtl/pe_ctrl_pkg.sv | 30 +++
 rtl/pe_array_load_ctrl_onehot_walker.sv | 37 +++
 rtl/pe_array_load_ctrl.sv | 135 +++++++++++++
 tb/tb_pe_array_load_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: types and sizing helpers shared by the PE array load
// sequencer and its one-hot select walker.
//   pe_ctrl_state_t : sequencer FSM state encoding
//   num_pe          : number of PEs in an M x N array
//   drain_cycles    : systolic drain skew, M + N - 1 cycles
//   idx_w           : width of the beat index, clog2(NUM_PE), at least 1
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } pe_ctrl_state_t;

    function automatic int num_pe(input int m, input int n);
        return m * n;
    endfunction

    function automatic int drain_cycles(input int m, input int n);
        return m + n - 1;
    endfunction

    function automatic int idx_w(input int m, input int n);
        return (m * n > 1) ? $clog2(m * n) : 1;
    endfunction

endpackage

// File: rtl/pe_array_load_ctrl_onehot_walker.sv
// onehot_walker: owns the registered one-hot PE select.
//   clk, reset : clock, async active-high reset
//   clear      : arm the walker so the next write targets PE0
//   advance    : a beat was accepted; register the current bit, shift left
//   gate       : registered write strobe; select reads all-zero without it
//   sel        : one-hot PE select
module onehot_walker #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             gate,
    output logic [WIDTH-1:0] sel
);

    // next_bit is the PE the following beat will write; sel_q is the PE
    // written by the beat accepted on the previous edge.
    logic [WIDTH-1:0] next_bit;
    logic [WIDTH-1:0] sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_bit <= '0;
            sel_q    <= '0;
        end else if (clear) begin
            next_bit <= WIDTH'(1);
        end else if (advance) begin
            sel_q    <= next_bit;
            next_bit <= next_bit << 1;
        end
    end

    assign sel = gate ? sel_q : '0;

endmodule

// File: rtl/pe_array_load_ctrl.sv
// pe_array_load_ctrl: per-job sequencer for the M x N PE array. Streams
// NUM_PE weight words from a valid/ready source into the PEs one at a time,
// holds the array in compute for cfg_k cycles, waits out the drain skew and
// pulses done.
//   clk, reset          : clock, async active-high reset
//   start, cfg_k        : job request (IDLE only) and its compute length
//   w_data, w_valid     : weight source; w_ready back to the source
//   pe_wen, pe_sel,
//   pe_wdata            : registered PE write port, one-hot select
//   comp_en, busy, done : array compute enable and job status
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; cfg_k latched on acceptance
// LOAD    | accepting weight beats, one PE write per beat
// SETTLE  | one cycle for the last PE write to land
// COMPUTE | array computing, cfg_k cycles
// DRAIN   | systolic skew drain, M+N-1 cycles
// DONE    | one-cycle done pulse
module pe_array_load_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int ARRAY_M    = 8,
    parameter int ARRAY_N    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          cfg_k,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic                          w_valid,
    output logic                          w_ready,
    output logic                          pe_wen,
    output logic [ARRAY_M*ARRAY_N-1:0]    pe_sel,
    output logic [DATA_WIDTH-1:0]         pe_wdata,
    output logic                          comp_en,
    output logic                          busy,
    output logic                          done
);

    localparam int NUM_PE       = num_pe(ARRAY_M, ARRAY_N);
    localparam int DRAIN_CYCLES = drain_cycles(ARRAY_M, ARRAY_N);
    localparam int IDX_W        = idx_w(ARRAY_M, ARRAY_N);
    localparam int DRN_W        = $clog2(DRAIN_CYCLES + 1);

    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_PE - 1);
    localparam logic [DRN_W-1:0]     DRAIN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [DRN_W-1:0]     DRAIN_ONE  = DRN_W'(1);
    localparam logic [CNT_WIDTH-1:0] COMP_ONE   = CNT_WIDTH'(1);

    pe_ctrl_state_t         state, next_state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_WIDTH-1:0]   comp_cnt;
    logic [DRN_W-1:0]       drain_cnt;
    logic                   accept;
    logic                   job_start;
    logic                   wen_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    assign job_start = (state == ST_IDLE) && start;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE:    if (start) next_state = ST_LOAD;
            ST_LOAD: begin
                if (w_valid) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) next_state = ST_SETTLE;
                end
            end
            ST_SETTLE:  next_state = (comp_cnt != '0) ? ST_COMPUTE : ST_DRAIN;
            ST_COMPUTE: if (comp_cnt == COMP_ONE) next_state = ST_DRAIN;
            ST_DRAIN:   if (drain_cnt == DRAIN_ONE) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            comp_cnt  <= '0;
            drain_cnt <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state <= next_state;
            wen_q <= accept;

            if (job_start)
                idx <= '0;
            else if (accept && idx != LAST_IDX)
                idx <= idx + IDX_W'(1);

            // Compute counter holds the latched k through LOAD/SETTLE and
            // counts down to terminal count 1 in COMPUTE.
            if (job_start)
                comp_cnt <= cfg_k;
            else if (state == ST_COMPUTE)
                comp_cnt <= comp_cnt - COMP_ONE;

            if (next_state == ST_DRAIN && state != ST_DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt - DRAIN_ONE;

            if (accept)
                wdata_q <= w_data;
        end
    end

    onehot_walker #(
        .WIDTH (NUM_PE)
    ) u_walker (
        .clk     (clk),
        .reset   (reset),
        .clear   (job_start),
        .advance (accept),
        .gate    (wen_q),
        .sel     (pe_sel)
    );

    assign pe_wen   = wen_q;
    assign pe_wdata = wdata_q;
    assign w_ready  = (state == ST_LOAD);
    assign comp_en  = (state == ST_COMPUTE);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_pe_array_load_ctrl.sv
module tb_pe_array_load_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] cfg_k;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic        pe_wen;
    logic [3:0]  pe_sel;
    logic [15:0] pe_wdata;
    logic        comp_en;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    pe_array_load_ctrl #(
        .ARRAY_M    (2),
        .ARRAY_N    (2),
        .DATA_WIDTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_k    (cfg_k),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .pe_wen   (pe_wen),
        .pe_sel   (pe_sel),
        .pe_wdata (pe_wdata),
        .comp_en  (comp_en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute cycle number; job-relative cycle = cyc - base (cycle 0 is
    // the cycle in which start is driven high).
    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          busy_cnt, comp_cnt, done_cnt, done_cyc, first_comp, last_comp;
    int          wen_n, sel_bad;
    logic [3:0]  wen_sel  [16];
    logic [15:0] wen_data [16];
    int          wen_cyc  [16];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (comp_en) begin
            if (first_comp < 0) first_comp = cyc - base;
            last_comp = cyc - base;
            comp_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - base;
        end
        if (pe_wen) begin
            if (wen_n < 16) begin
                wen_sel[wen_n]  = pe_sel;
                wen_data[wen_n] = pe_wdata;
                wen_cyc[wen_n]  = cyc - base;
            end
            wen_n++;
        end else if (pe_sel !== 4'b0000) begin
            sel_bad++;
        end
    end

    task automatic clear_mon();
        busy_cnt = 0; comp_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_comp = -1; last_comp = -1; wen_n = 0; sel_bad = 0;
    endtask

    // Called at posedge+#1; drives start for exactly one cycle.
    task automatic start_job(input logic [15:0] k);
        clear_mon();
        base  = cyc;
        cfg_k = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one word and returns at posedge+#1 after it is accepted.
    task automatic send_beat(input logic [15:0] d);
        bit seen = 1'b0;
        w_valid = 1'b1;
        w_data  = d;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = w_ready;
        end
        if (!seen) begin
            total++;
            $display("FAIL beat_timeout: w_ready never high for word %h", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int budget);
        total++;
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) $display("FAIL done_timeout: no done within %0d cycles", budget);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int r);
        for (int i = 0; i < 200000 && (cyc - base) < r; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cfg_k = '0; w_data = '0; w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({w_ready, pe_wen, pe_sel, pe_wdata, comp_en, busy, done} !== 25'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {w_ready, pe_wen, pe_sel, pe_wdata, comp_en, busy, done});
        else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [3:0] exp_sel;
        start_job(16'd5);
        total++;
        if (w_ready !== 1'b1) $display("FAIL basic_ready_c1: got %b expected 1", w_ready);
        else passed++;
        for (int i = 0; i < 4; i++) send_beat(16'h00A0 + 16'(i));
        w_valid = 1'b0;
        wait_done(100);
        chk("basic_wen_n", wen_n, 4);
        for (int i = 0; i < 4; i++) begin
            exp_sel = 4'b0001 << i;
            chk($sformatf("basic_sel%0d", i), int'(wen_sel[i]), int'(exp_sel));
            chk($sformatf("basic_data%0d", i), int'(wen_data[i]), 16'h00A0 + i);
            chk($sformatf("basic_wcyc%0d", i), wen_cyc[i], 2 + i);
        end
        chk("basic_comp_cnt", comp_cnt, 5);
        chk("basic_first_comp", first_comp, 6);
        chk("basic_drain_gap", done_cyc - last_comp, 4);
        chk("basic_done_cyc", done_cyc, 14);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_busy_cnt", busy_cnt, 14);
        chk("basic_sel_gating", sel_bad, 0);
    endtask

    task automatic test_k0();
        start_job(16'd0);
        for (int i = 0; i < 4; i++) send_beat(16'h0010 + 16'(i));
        w_valid = 1'b0;
        wait_done(100);
        chk("k0_comp_cnt", comp_cnt, 0);
        chk("k0_done_after_settle", done_cyc - wen_cyc[3], 4);
        chk("k0_busy_cnt", busy_cnt, 9);
    endtask

    task automatic test_stall();
        int exp_c [4] = '{2, 3, 8, 9};
        logic [3:0] exp_sel;
        start_job(16'd2);
        send_beat(16'h00D0);
        send_beat(16'h00D1);
        w_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_beat(16'h00D2);
        send_beat(16'h00D3);
        w_valid = 1'b0;
        wait_done(100);
        chk("stall_wen_n", wen_n, 4);
        for (int i = 0; i < 4; i++) begin
            exp_sel = 4'b0001 << i;
            chk($sformatf("stall_sel%0d", i), int'(wen_sel[i]), int'(exp_sel));
            chk($sformatf("stall_data%0d", i), int'(wen_data[i]), 16'h00D0 + i);
            chk($sformatf("stall_wcyc%0d", i), wen_cyc[i], exp_c[i]);
        end
        chk("stall_done_cyc", done_cyc, 15);
        chk("stall_sel_gating", sel_bad, 0);
    endtask

    task automatic test_ignored_start();
        start_job(16'd3);
        send_beat(16'h0050);
        send_beat(16'h0051);
        cfg_k = 16'd9;
        start = 1'b1;
        send_beat(16'h0052);
        start = 1'b0;
        send_beat(16'h0053);
        w_valid = 1'b0;
        wait_rel(7);
        start = 1'b1;
        wait_rel(8);
        start = 1'b0;
        wait_rel(12);
        start = 1'b1;
        wait_rel(13);
        start = 1'b0;
        wait_rel(16);
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_done_cyc", done_cyc, 12);
        chk("ign_comp_cnt", comp_cnt, 3);
        chk("ign_busy_cnt", busy_cnt, 12);
        chk("ign_idle_after", int'(busy), 0);
    endtask

    task automatic test_back_to_back();
        start_job(16'd1);
        for (int i = 0; i < 4; i++) send_beat(16'h0060 + 16'(i));
        w_valid = 1'b0;
        wait_rel(10);
        chk("b2b_done_a", int'(done), 1);
        wait_rel(11);
        start_job(16'd2);
        chk("b2b_ready_b", int'(w_ready), 1);
        for (int i = 0; i < 4; i++) send_beat(16'h0070 + 16'(i));
        w_valid = 1'b0;
        wait_done(100);
        chk("b2b_sel0_b", int'(wen_sel[0]), 1);
        chk("b2b_data0_b", int'(wen_data[0]), 16'h0070);
        chk("b2b_done_cyc_b", done_cyc, 11);
        chk("b2b_comp_cnt_b", comp_cnt, 2);
    endtask

    task automatic test_mid_load_reset();
        start_job(16'd5);
        send_beat(16'h00B0);
        send_beat(16'h00B1);
        send_beat(16'h00B2);
        chk("rst_busy_before", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({w_ready, pe_wen, pe_sel, pe_wdata, comp_en, busy, done} !== 25'd0)
            $display("FAIL midreset_outputs: got %h expected 0",
                     {w_ready, pe_wen, pe_sel, pe_wdata, comp_en, busy, done});
        else passed++;
        w_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_job(16'd1);
        for (int i = 0; i < 4; i++) send_beat(16'h00C0 + 16'(i));
        w_valid = 1'b0;
        wait_done(100);
        chk("rst_wen_n", wen_n, 4);
        chk("rst_sel0", int'(wen_sel[0]), 1);
        chk("rst_data0", int'(wen_data[0]), 16'h00C0);
        chk("rst_sel3", int'(wen_sel[3]), 8);
        chk("rst_done_cyc", done_cyc, 10);
    endtask

    task automatic test_max_k();
        start_job(16'hFFFF);
        for (int i = 0; i < 4; i++) send_beat(16'h00E0 + 16'(i));
        w_valid = 1'b0;
        wait_done(70000);
        chk("maxk_comp_cnt", comp_cnt, 65535);
        chk("maxk_first_comp", first_comp, 6);
        chk("maxk_done_cyc", done_cyc, 65544);
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_k0();
        test_stall();
        test_ignored_start();
        test_back_to_back();
        test_mid_load_reset();
        test_max_k();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
